// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared types and constants for the 5-stage pipeline control path.
package pipeline_pkg;
  localparam int REG_ADDR_W = 5;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  typedef enum logic [1:0] {RUN, MEM_WAIT, ERROR} hazState_t;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rstN,
  input  logic         inc,
  output logic [W-1:0] count
);
  logic [W-1:0] count_q, count_d;
  always_comb count_d = (inc && !(&count_q)) ? count_q + W'(1) : count_q;
  always_ff @(posedge clk) count_q <= !rstN ? '0 : count_d;
  assign count = count_q;
endmodule

// File: rtl/hazard_control_unit.sv
// hazard_control_unit: load-use stall, branch flush, memory freeze/timeout and perf counters.
module hazard_control_unit import pipeline_pkg::*; #(
  parameter int COUNT_W  = 32,
  parameter int MAX_WAIT = 255
) (
  input  logic                  clk,
  input  logic                  rstN,
  input  logic [REG_ADDR_W-1:0] idRs1,
  input  logic [REG_ADDR_W-1:0] idRs2,
  input  logic                  idUsesRs1,
  input  logic                  idUsesRs2,
  input  logic                  exMemRead,
  input  logic [REG_ADDR_W-1:0] exRd,
  input  logic                  exBranchTaken,
  input  logic                  memReq,
  input  logic                  memReady,
  output logic                  pcWriteEnable,
  output logic                  ifIdWriteEnable,
  output logic                  idExWriteEnable,
  output logic                  exMemWriteEnable,
  output logic                  memWbWriteEnable,
  output logic                  ifIdFlush,
  output logic                  idExFlush,
  output logic                  timeoutError,
  output logic [COUNT_W-1:0]    loadUseStallCount,
  output logic [COUNT_W-1:0]    memStallCount,
  output logic [COUNT_W-1:0]    flushCount
);
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  hazState_t state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d, wait_next;
  logic load_use, mem_wait, active, freeze, flush, stall;
  always_comb begin
    load_use  = exMemRead && (exRd != '0) &&
                ((idUsesRs1 && idRs1 == exRd) || (idUsesRs2 && idRs2 == exRd));
    mem_wait  = memReq && !memReady;
    active    = rstN && (state_q != ERROR);
    freeze    = active && mem_wait;
    flush     = active && !mem_wait && exBranchTaken;
    stall     = active && !mem_wait && !exBranchTaken && load_use;
    // wait_next counts the current wait cycle, so the edge ending the MAX_WAIT-th one enters ERROR
    wait_next = (state_q == MEM_WAIT) ? wait_cnt_q + WAIT_W'(1) : WAIT_W'(1);
    state_d    = (state_q == ERROR) ? ERROR :
                 mem_wait ? ((wait_next >= WAIT_W'(MAX_WAIT)) ? ERROR : MEM_WAIT) : RUN;
    wait_cnt_d = (state_q == ERROR) ? wait_cnt_q : mem_wait ? wait_next : '0;
  end
  always_ff @(posedge clk) begin
    state_q    <= !rstN ? RUN : state_d;
    wait_cnt_q <= !rstN ? '0 : wait_cnt_d;
  end
  assign pcWriteEnable    = active && !mem_wait && !stall;
  assign ifIdWriteEnable  = active && !mem_wait && !stall;
  assign idExWriteEnable  = active && !mem_wait;
  assign exMemWriteEnable = active && !mem_wait;
  assign memWbWriteEnable = active && !mem_wait;
  assign ifIdFlush        = flush;
  assign idExFlush        = flush || stall;
  assign timeoutError     = rstN && (state_q == ERROR);
  sat_counter #(.W(COUNT_W)) u_lu_cnt (.clk(clk), .rstN(rstN), .inc(stall),  .count(loadUseStallCount));
  sat_counter #(.W(COUNT_W)) u_ms_cnt (.clk(clk), .rstN(rstN), .inc(freeze), .count(memStallCount));
  sat_counter #(.W(COUNT_W)) u_fl_cnt (.clk(clk), .rstN(rstN), .inc(flush),  .count(flushCount));
endmodule
